// File: rtl/writeback_pkg.sv
// rtl/writeback_pkg.sv - RV32I writeback constants, opcode/funct3 codes and load formatting
package writeback_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    localparam logic [XLEN-1:0] NOP_BUBBLE = 32'h00000013;

    typedef struct packed {
        logic            en;
        logic [XLEN-1:0] data;
    } result_t;

    // Undefined load widths come back with en clear so they never write
    function automatic result_t format_load(input logic [2:0] funct3, input logic [XLEN-1:0] raw);
        result_t r;
        r.en   = 1'b1;
        r.data = '0;
        case (funct3)
            F3_LB:   r.data = {{24{raw[7]}}, raw[7:0]};
            F3_LH:   r.data = {{16{raw[15]}}, raw[15:0]};
            F3_LW:   r.data = raw;
            F3_LBU:  r.data = {24'b0, raw[7:0]};
            F3_LHU:  r.data = {16'b0, raw[15:0]};
            default: r.en   = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 31x32 architectural register file, one write port, two bypassed read ports
module reg_file
    import writeback_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] regs [1:NREG-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we && waddr != 5'd0) begin
            regs[waddr] <= wdata;
        end
    end

    // Write-through bypass lets decode see the value committing this cycle
    always_comb begin
        rdata1 = '0;
        if (raddr1 != 5'd0) begin
            if (we && waddr == raddr1) rdata1 = wdata;
            else                       rdata1 = regs[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (raddr2 != 5'd0) begin
            if (we && waddr == raddr2) rdata2 = wdata;
            else                       rdata2 = regs[raddr2];
        end
    end

endmodule

// File: rtl/writeback.sv
// rtl/writeback.sv - RV32I writeback stage: result select, register commit, instret counter
module writeback
    import writeback_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] IR,
    input  logic [XLEN-1:0] RD,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] PC,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            wb_en,
    output logic [4:0]      wb_addr,
    output logic [XLEN-1:0] wb_data,
    output logic [63:0]     instret
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    result_t    res;
    logic       bubble;

    assign opcode  = IR[6:0];
    assign funct3  = IR[14:12];
    assign wb_addr = IR[11:7];

    always_comb begin
        res = '0;
        case (opcode)
            OP_LOAD:                        res = format_load(funct3, RD);
            OP_OP, OP_IMM, OP_LUI, OP_AUIPC: res = '{en: 1'b1, data: A};
            OP_JAL, OP_JALR:                res = '{en: 1'b1, data: PC + 32'd4};
            OP_STORE, OP_BRANCH:            res = '0;
            default:                        res = '0;
        endcase
    end

    assign wb_en   = res.en && (wb_addr != 5'd0);
    assign wb_data = res.data;

    assign bubble = (IR == NOP_BUBBLE) || (IR == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       instret <= '0;
        else if (!bubble) instret <= instret + 64'd1;
    end

    reg_file u_reg_file (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (wb_en),
        .waddr  (wb_addr),
        .wdata  (wb_data),
        .raddr1 (rs1_addr),
        .raddr2 (rs2_addr),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data)
    );

endmodule

// File: tb/tb_writeback.sv
// tb/tb_writeback.sv - self-checking bench for writeback: vector table, corner sequences, random vs model
module tb_writeback;

    logic        clk;
    logic        rst_n;
    logic [31:0] IR, RD, A, PC;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [63:0] instret;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_regs [0:31];
    logic [63:0] m_instret;

    writeback dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .IR       (IR),
        .RD       (RD),
        .A        (A),
        .PC       (PC),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .instret  (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3);
        return {12'h001, 5'd0, f3, rd, op};
    endfunction

    // Reference: what the spec says a given instruction writes
    task automatic ref_result(input logic [31:0] ir, input logic [31:0] rd, input logic [31:0] a,
                              input logic [31:0] pc, output logic en, output logic [31:0] data);
        logic [6:0] op;
        logic [2:0] f3;
        op = ir[6:0];
        f3 = ir[14:12];
        en = 1'b0;
        data = 32'd0;
        if (op == 7'b0000011) begin
            en = 1'b1;
            if      (f3 == 3'd0) data = 32'($signed(rd[7:0]));
            else if (f3 == 3'd1) data = 32'($signed(rd[15:0]));
            else if (f3 == 3'd2) data = rd;
            else if (f3 == 3'd4) data = rd % 256;
            else if (f3 == 3'd5) data = rd % 65536;
            else en = 1'b0;
        end else if (op == 7'b0110011 || op == 7'b0010011 || op == 7'b0110111 || op == 7'b0010111) begin
            en = 1'b1;
            data = a;
        end else if (op == 7'b1101111 || op == 7'b1100111) begin
            en = 1'b1;
            data = 32'((64'(pc) + 64'd4) % 64'h1_0000_0000);
        end
        if (ir[11:7] == 5'd0) en = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_instret = 64'd0;
    endtask

    // Called at a negedge; drives one instruction, checks combinational outputs, commits, checks instret
    task automatic step(input logic [31:0] ir, input logic [31:0] rd, input logic [31:0] a, input logic [31:0] pc,
                        input logic [4:0] r1, input logic [4:0] r2,
                        input bit use_exp, input logic exp_en, input logic [31:0] exp_data);
        logic        m_en;
        logic [31:0] m_data, e1, e2;
        IR = ir; RD = rd; A = a; PC = pc; rs1_addr = r1; rs2_addr = r2;
        #1;
        ref_result(ir, rd, a, pc, m_en, m_data);
        if (use_exp) begin
            m_en = exp_en;
            m_data = exp_data;
        end
        check("wb_en", 64'(wb_en), 64'(m_en));
        if (m_en) begin
            check("wb_addr", 64'(wb_addr), 64'(ir[11:7]));
            check("wb_data", 64'(wb_data), 64'(m_data));
        end
        e1 = (m_en && ir[11:7] == r1) ? m_data : m_regs[r1];
        e2 = (m_en && ir[11:7] == r2) ? m_data : m_regs[r2];
        check("rs1_data", 64'(rs1_data), 64'(e1));
        check("rs2_data", 64'(rs2_data), 64'(e2));
        @(posedge clk);
        if (m_en) m_regs[ir[11:7]] = m_data;
        if (ir != 32'h00000013 && ir != 32'h00000000) m_instret = m_instret + 64'd1;
        @(negedge clk);
        check("instret", instret, m_instret);
    endtask

    typedef struct {
        logic [31:0] ir, rd, a, pc;
        logic [4:0]  r1, r2;
        logic        en;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[$];
    logic [6:0] ops [0:10];

    initial begin
        logic [63:0] saved;
        logic [31:0] rir;
        vec_t v;

        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111,
                7'b1101111, 7'b1100111, 7'b1100011, 7'b0001111, 7'b1111111};

        rst_n = 1'b0;
        IR = 32'd0; RD = 32'd0; A = 32'd0; PC = 32'd0; rs1_addr = 5'd0; rs2_addr = 5'd0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(31 - i);
            #1;
            check("reset_rs1", 64'(rs1_data), 64'd0);
            check("reset_rs2", 64'(rs2_data), 64'd0);
        end
        check("reset_instret", instret, 64'd0);
        rst_n = 1'b1;

        vecs.push_back('{mk(7'b0000011, 5, 0), 32'h000000F0, 0, 0, 5, 0, 1'b1, 32'hFFFFFFF0});
        vecs.push_back('{mk(7'b0000011, 6, 4), 32'h000000F0, 0, 0, 5, 6, 1'b1, 32'h000000F0});
        vecs.push_back('{mk(7'b0000011, 8, 1), 32'h00008001, 0, 0, 6, 8, 1'b1, 32'hFFFF8001});
        vecs.push_back('{mk(7'b0000011, 9, 5), 32'h00008001, 0, 0, 9, 5, 1'b1, 32'h00008001});
        vecs.push_back('{mk(7'b0000011, 10, 2), 32'h89ABCDEF, 0, 0, 10, 8, 1'b1, 32'h89ABCDEF});
        vecs.push_back('{mk(7'b0110011, 2, 0), 0, 32'hAAAA5555, 0, 2, 9, 1'b1, 32'hAAAA5555});
        vecs.push_back('{mk(7'b0010011, 0, 0), 0, 32'h12345678, 0, 0, 0, 1'b0, 32'h0});
        vecs.push_back('{mk(7'b1101111, 1, 0), 0, 0, 32'hFFFFFFFC, 1, 2, 1'b1, 32'h00000000});
        vecs.push_back('{mk(7'b1100111, 3, 0), 0, 0, 32'h00000100, 3, 1, 1'b1, 32'h00000104});
        vecs.push_back('{mk(7'b0110111, 4, 0), 0, 32'h12345000, 0, 4, 3, 1'b1, 32'h12345000});
        vecs.push_back('{mk(7'b0010111, 11, 0), 0, 32'h00001000, 0, 11, 4, 1'b1, 32'h00001000});
        vecs.push_back('{mk(7'b0100011, 5, 2), 32'h11111111, 32'h22222222, 0, 5, 6, 1'b0, 32'h0});
        vecs.push_back('{mk(7'b1100011, 6, 1), 32'h11111111, 32'h22222222, 0, 6, 5, 1'b0, 32'h0});
        vecs.push_back('{mk(7'b0000011, 12, 3), 32'h33333333, 0, 0, 12, 5, 1'b0, 32'h0});
        vecs.push_back('{mk(7'b0000011, 12, 6), 32'h33333333, 0, 0, 12, 6, 1'b0, 32'h0});
        vecs.push_back('{mk(7'b0000011, 12, 7), 32'h33333333, 0, 0, 12, 8, 1'b0, 32'h0});

        foreach (vecs[i]) begin
            v = vecs[i];
            step(v.ir, v.rd, v.a, v.pc, v.r1, v.r2, 1'b1, v.en, v.data);
        end

        // Bubbles never count
        saved = instret;
        step(32'h00000013, 0, 32'h5, 0, 1, 2, 1'b1, 1'b0, 32'h0);
        step(32'h00000000, 0, 32'h5, 0, 1, 2, 1'b1, 1'b0, 32'h0);
        check("bubble_instret", instret, saved);

        // Stored values after bypass cycle equal the committed ones
        step(32'h00000013, 0, 0, 0, 5, 6, 1'b1, 1'b0, 32'h0);
        check("x5_stored", 64'(rs1_data), 64'hFFFFFFF0);
        check("x6_stored", 64'(rs2_data), 64'h000000F0);

        // Consecutive writes to the same register: the later one wins
        step(mk(7'b0110011, 13, 0), 0, 32'h01010101, 0, 13, 0, 1'b1, 1'b1, 32'h01010101);
        step(mk(7'b0110011, 13, 0), 0, 32'h02020202, 0, 13, 0, 1'b1, 1'b1, 32'h02020202);
        step(32'h00000013, 0, 0, 0, 13, 13, 1'b1, 1'b0, 32'h0);
        check("x13_later_wins", 64'(rs1_data), 64'h02020202);

        // Asynchronous reset while an OP to x7 is in flight
        IR = mk(7'b0110011, 7, 0); A = 32'hDEADBEEF; rs1_addr = 5'd7; rs2_addr = 5'd13;
        #2;
        rst_n = 1'b0;
        #1;
        IR = 32'd0;
        #1;
        check("async_rs2", 64'(rs2_data), 64'd0);
        check("async_instret", instret, 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("reset_x7", 64'(rs1_data), 64'd0);
        check("reset_instret2", instret, 64'd0);
        model_reset();
        rst_n = 1'b1;

        for (int n = 0; n < 400; n++) begin
            rir = $urandom();
            rir[6:0] = ops[$urandom_range(0, 10)];
            if ($urandom_range(0, 15) == 0) rir = 32'h00000013;
            if ($urandom_range(0, 31) == 0) rir = 32'h00000000;
            step(rir, $urandom(), $urandom(), $urandom(),
                 ($urandom_range(0, 3) == 0) ? rir[11:7] : 5'($urandom_range(0, 31)),
                 ($urandom_range(0, 3) == 0) ? rir[11:7] : 5'($urandom_range(0, 31)),
                 1'b0, 1'b0, 32'h0);
        end

        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(i);
            IR = 32'h00000013;
            #1;
            check("final_rs1", 64'(rs1_data), 64'(m_regs[i]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
